// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: datapath width, reset vector and the
// fetch-queue entry layout used between fetch and decode.
package rv_core_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_checker.sv
// Invariant monitor for the fetch unit: the instruction queue never receives
// a response while full, and the in-flight/drop counters stay bounded.
module fetch_unit_checker #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             rsp_fire_i,
    input logic             q_full_i,
    input logic [CNT_W-1:0] outstanding_i,
    input logic [CNT_W-1:0] drop_cnt_i
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

    a_no_rsp_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_fire_i && q_full_i));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_i <= MAX_CNT);

    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt_i <= MAX_CNT);

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage, occupancy count and a
// flush that empties it in one cycle (flush dominates push and pop).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign push_s  = push_i && !full_o && !flush_i;
    assign pop_s   = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_s) begin
                wr_d = ptr_inc(wr_q);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = ptr_inc(rd_q);
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues word requests, tags them with
// their PC and queues returned instructions for decode; redirects flush.
module fetch_unit
    import rv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2,
    parameter int              CNT_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             fetch_en_q;

    logic [CNT_W-1:0] tag_count_s;
    logic             tag_full_s, tag_empty_s;
    logic [XLEN-1:0]  tag_pc_s;
    logic [CNT_W-1:0] q_count_s;
    logic             q_full_s, q_empty_s;
    fetch_entry_t     q_wdata_s, q_rdata_s;

    logic [CNT_W:0]   occupancy_s;
    logic [CNT_W:0]   inflight_s;
    logic             req_valid_s;
    logic             accept_s;
    logic             rsp_fire_s;
    logic             q_push_s;
    logic             q_pop_s;

    // Outstanding requests are exactly the entries in the PC-tag FIFO.
    assign occupancy_s = {1'b0, tag_count_s} + {1'b0, q_count_s};
    assign inflight_s  = {1'b0, tag_count_s} + (CNT_W+1)'(accept_s)
                         - (CNT_W+1)'(rsp_fire_s);

    // Handshake qualification for memory and decode sides.
    always_comb begin
        req_valid_s = 1'b0;
        if (fetch_en_q && !redirect_valid && (drop_q == '0) && !tag_full_s &&
            (occupancy_s < (CNT_W+1)'(DEPTH))) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s   = req_valid_s && imem_req_ready;
        rsp_fire_s = imem_rsp_valid && !tag_empty_s;
        q_push_s   = rsp_fire_s && (drop_q == '0) && !redirect_valid;
        q_pop_s    = !q_empty_s && id_ready && !redirect_valid;
    end

    // PC and stale-response drop counter next-state.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = align_word(redirect_pc);
            drop_d = CNT_W'(inflight_s);
        end else begin
            if (accept_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            if (rsp_fire_s && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Fetch state registers; fetch_en_q holds requests off during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            drop_q     <= '0;
            fetch_en_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            fetch_en_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept_s),
        .pop_i   (rsp_fire_s),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (tag_pc_s),
        .full_o  (tag_full_s),
        .empty_o (tag_empty_s),
        .count_o (tag_count_s)
    );

    assign q_wdata_s = '{pc: tag_pc_s, instr: imem_rsp_data};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_instr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push_s),
        .pop_i   (q_pop_s),
        .flush_i (redirect_valid),
        .wdata_i (q_wdata_s),
        .rdata_o (q_rdata_s),
        .full_o  (q_full_s),
        .empty_o (q_empty_s),
        .count_o (q_count_s)
    );

    fetch_unit_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsp_fire_i    (rsp_fire_s),
        .q_full_i      (q_full_s),
        .outstanding_i (tag_count_s),
        .drop_cnt_i    (drop_q)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign id_valid       = !q_empty_s;
    assign id_instr       = q_rdata_s.instr;
    assign id_pc          = q_rdata_s.pc;

endmodule
